// File: rtl/i2s_rx_frame_assembler.sv
// i2s_rx_frame_assembler: pairs per-channel codec words into L/R stereo frames.
// It rounds and saturates each sample from IN_RES to OUT_W bits.
// It flags saturation, channel sequence errors and input dropout.
// Optional peak meter output peak_o is built only when PEAK_METER_EN is defined.
module i2s_rx_frame_assembler #(
  parameter int unsigned IN_RES  = 24,
  parameter int unsigned OUT_W   = 16,
  parameter bit          SWAP    = 1'b0,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             lmmi_clk_i,
  input  logic             reset,
  input  logic [31:0]      sample_dat_i,
  input  logic             sample_vld_i,
  input  logic             ws_i,
  output logic [OUT_W-1:0] left_o,
  output logic [OUT_W-1:0] right_o,
  output logic             frame_vld_o,
  output logic             sat_o,
  output logic             dropout_o,
  output logic             seq_err_o,
  input  logic             clr_i
`ifdef PEAK_METER_EN
  ,
  output logic [OUT_W-1:0] peak_o
`endif
);

  localparam int unsigned SHIFT = IN_RES - OUT_W;
  localparam int unsigned SUM_W = IN_RES + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic signed [SUM_W-1:0] RND   = SUM_W'(2 ** (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] MAX_E = SUM_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] MIN_E = ~MAX_E;
  localparam logic [CNT_W-1:0]        TMO   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_L  = 2'd0,
    WAIT_R  = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t state;

  logic             ws_m;
  logic             ws_s;

  logic             conv_vld;
  logic             conv_ch;
  logic [OUT_W-1:0] conv_dat;

  logic             skid_full;
  logic             skid_ch;
  logic [OUT_W-1:0] skid_dat;

  logic [OUT_W-1:0] held_l;
  logic [CNT_W-1:0] cnt_q;

  logic signed [SUM_W-1:0] x_ext_c;
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] shr_c;
  logic [OUT_W-1:0]        conv_c;
  logic                    sat_c;
  logic [CNT_W-1:0]        cnt_nxt_c;
  logic                    timeout_c;
  logic                    item_vld_c;
  logic                    item_ch_c;
  logic [OUT_W-1:0]        item_dat_c;

  // Bits above the sample resolution carry no information.
  logic unused_hi;
  assign unused_hi = ^sample_dat_i[31:IN_RES];

  // Two-flop synchronizer for the word select coming from the other clock domain.
  always_ff @(posedge lmmi_clk_i or posedge reset) begin
    if (reset) begin
      ws_m <= 1'b0;
      ws_s <= 1'b0;
    end else begin
      ws_m <= ws_i;
      ws_s <= ws_m;
    end
  end

  // Round half-up at the dropped LSBs, arithmetic shift, clamp to OUT_W.
  always_comb begin
    x_ext_c = {sample_dat_i[IN_RES-1], sample_dat_i[IN_RES-1:0]};
    sum_c   = x_ext_c + RND;
    shr_c   = sum_c >>> SHIFT;
    sat_c   = 1'b0;
    conv_c  = shr_c[OUT_W-1:0];
    if (shr_c > MAX_E) begin
      conv_c = MAX_E[OUT_W-1:0];
      sat_c  = 1'b1;
    end else if (shr_c < MIN_E) begin
      conv_c = MIN_E[OUT_W-1:0];
      sat_c  = 1'b1;
    end
  end

  // Conversion stage: one cycle after the valid pulse, tagged with its channel.
  always_ff @(posedge lmmi_clk_i or posedge reset) begin
    if (reset) begin
      conv_vld <= 1'b0;
      conv_ch  <= 1'b0;
      conv_dat <= '0;
    end else begin
      conv_vld <= sample_vld_i;
      if (sample_vld_i) begin
        conv_ch  <= ws_s ^ SWAP;
        conv_dat <= conv_c;
      end
    end
  end

  // Sticky saturation flag; a new clamp in the clear cycle wins.
  always_ff @(posedge lmmi_clk_i or posedge reset) begin
    if (reset) begin
      sat_o <= 1'b0;
    end else begin
      sat_o <= (sat_o & ~clr_i) | (sample_vld_i & sat_c);
    end
  end

  // Idle counter saturating at TIMEOUT; any valid pulse restarts it.
  always_comb begin
    if (sample_vld_i) begin
      cnt_nxt_c = '0;
    end else if (cnt_q == TMO) begin
      cnt_nxt_c = TMO;
    end else begin
      cnt_nxt_c = cnt_q + CNT_W'(1);
    end
    timeout_c = (cnt_nxt_c == TMO);
  end

  // Dropout counter and its flag, which follows the counter directly.
  always_ff @(posedge lmmi_clk_i or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      dropout_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_nxt_c;
      dropout_o <= timeout_c;
    end
  end

  // A sample parked in the skid register is older than the conversion stage, so it goes first.
  always_comb begin
    if (skid_full) begin
      item_vld_c = 1'b1;
      item_ch_c  = skid_ch;
      item_dat_c = skid_dat;
    end else begin
      item_vld_c = conv_vld;
      item_ch_c  = conv_ch;
      item_dat_c = conv_dat;
    end
  end

  // Channel pairing FSM with skid capture during PUBLISH and dropout recovery.
  always_ff @(posedge lmmi_clk_i or posedge reset) begin
    if (reset) begin
      state       <= WAIT_L;
      held_l      <= '0;
      skid_full   <= 1'b0;
      skid_ch     <= 1'b0;
      skid_dat    <= '0;
      left_o      <= '0;
      right_o     <= '0;
      frame_vld_o <= 1'b0;
      seq_err_o   <= 1'b0;
    end else begin
      frame_vld_o <= 1'b0;
      seq_err_o   <= seq_err_o & ~clr_i;
      if (timeout_c) begin
        state     <= WAIT_L;
        held_l    <= '0;
        skid_full <= 1'b0;
        left_o    <= '0;
        right_o   <= '0;
      end else if (state == PUBLISH) begin
        state <= WAIT_L;
        if (conv_vld) begin
          skid_full <= 1'b1;
          skid_ch   <= conv_ch;
          skid_dat  <= conv_dat;
          if (skid_full) begin
            seq_err_o <= 1'b1;
          end
        end
      end else begin
        if (skid_full) begin
          if (conv_vld) begin
            skid_ch  <= conv_ch;
            skid_dat <= conv_dat;
          end else begin
            skid_full <= 1'b0;
          end
        end
        if (item_vld_c) begin
          case (state)
            WAIT_L: begin
              if (!item_ch_c) begin
                held_l <= item_dat_c;
                state  <= WAIT_R;
              end else begin
                seq_err_o <= 1'b1;
              end
            end
            WAIT_R: begin
              if (item_ch_c) begin
                left_o      <= held_l;
                right_o     <= item_dat_c;
                frame_vld_o <= 1'b1;
                state       <= PUBLISH;
              end else begin
                held_l    <= item_dat_c;
                seq_err_o <= 1'b1;
              end
            end
            default: state <= WAIT_L;
          endcase
        end
      end
    end
  end

`ifdef PEAK_METER_EN
  logic [9:0]       decay_cnt;
  logic [OUT_W-1:0] mag_l_c;
  logic [OUT_W-1:0] mag_r_c;
  logic [OUT_W-1:0] mag_c;

  function automatic logic [OUT_W-1:0] mag(input logic [OUT_W-1:0] v);
    if (!v[OUT_W-1]) begin
      return v;
    end else if (v == {1'b1, {(OUT_W-1){1'b0}}}) begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      return ~v + OUT_W'(1);
    end
  endfunction

  // Larger magnitude of the published pair.
  always_comb begin
    mag_l_c = mag(left_o);
    mag_r_c = mag(right_o);
    mag_c   = (mag_l_c > mag_r_c) ? mag_l_c : mag_r_c;
  end

  // Peak hold: a new maximum restarts the decay count, otherwise decay by 1 every 1024 frames.
  always_ff @(posedge lmmi_clk_i or posedge reset) begin
    if (reset) begin
      peak_o    <= '0;
      decay_cnt <= '0;
    end else if (clr_i) begin
      peak_o    <= '0;
      decay_cnt <= '0;
    end else if (frame_vld_o) begin
      if (mag_c > peak_o) begin
        peak_o    <= mag_c;
        decay_cnt <= '0;
      end else if (decay_cnt == 10'd1023) begin
        decay_cnt <= '0;
        if (peak_o != '0) begin
          peak_o <= peak_o - OUT_W'(1);
        end
      end else begin
        decay_cnt <= decay_cnt + 10'd1;
      end
    end
  end
`endif

endmodule
